// File: rtl/axis_packet_collector.sv
// Collects N_BEATS AXI-Stream beats into one wide packet with a packet-level valid/ready port.
// Optional AXIS_COLLECT_LAST_EN adds s_last framing with an m_err flag.
module axis_packet_collector #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned N_BEATS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BUS_W-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N_BEATS*BUS_W-1:0]   m_data
`ifdef AXIS_COLLECT_LAST_EN
  ,
  input  logic                       s_last,
  output logic                       m_err
`endif
);

  localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W;
  localparam int unsigned CNT_W          = $clog2(N_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_BEATS - 1);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       s_ready_q, s_ready_d;
  logic                       m_valid_q, m_valid_d;
  logic [N_BEATS*BUS_W-1:0]   m_data_q, m_data_d;
  logic                       accept;
  logic                       close;
`ifdef AXIS_COLLECT_LAST_EN
  logic                       m_err_q, m_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    close     = 1'b0;
`ifdef AXIS_COLLECT_LAST_EN
    m_err_d   = m_err_q;
`endif
    accept    = s_valid && s_ready_q;

    unique case (state_q)
      StFill: begin
        s_ready_d = 1'b1;
        if (accept) begin
`ifdef AXIS_COLLECT_LAST_EN
          // Fresh packet starts zeroed so an early s_last leaves empty slots at 0.
          if (cnt_q == '0) m_data_d = '0;
`endif
          for (int unsigned i = 0; i < N_BEATS; i++) begin
            for (int unsigned w = 0; w < WORDS_PER_BEAT; w++) begin
              if (cnt_q == CNT_W'(i)) begin
                m_data_d[i*BUS_W + w*WORD_W +: WORD_W] = s_data[w*WORD_W +: WORD_W];
              end
            end
          end
`ifdef AXIS_COLLECT_LAST_EN
          close   = (cnt_q == LAST_CNT) || s_last;
          m_err_d = !((cnt_q == LAST_CNT) && s_last);
`else
          close   = (cnt_q == LAST_CNT);
`endif
          if (close) begin
            cnt_d     = '0;
            m_valid_d = 1'b1;
            s_ready_d = 1'b0;
            state_d   = StHold;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StHold: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = StFill;
`ifdef AXIS_COLLECT_LAST_EN
          m_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`ifdef AXIS_COLLECT_LAST_EN
      m_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`ifdef AXIS_COLLECT_LAST_EN
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
`ifdef AXIS_COLLECT_LAST_EN
  assign m_err   = m_err_q;
`endif

endmodule

// File: tb/tb_axis_packet_collector.sv
// Self-checking bench for axis_packet_collector: queue-based packet model compared every cycle,
// plus directed literal checks.
module tb_axis_packet_collector;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned BUS_W   = 8;
  localparam int unsigned N_BEATS = 10;
  localparam int unsigned PKT_W   = N_BEATS * BUS_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [BUS_W-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [PKT_W-1:0] m_data;
`ifdef AXIS_COLLECT_LAST_EN
  logic             s_last = 1'b0;
  logic             m_err;
`endif

  axis_packet_collector #(
    .WORD_W (WORD_W),
    .BUS_W  (BUS_W),
    .N_BEATS(N_BEATS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
`ifdef AXIS_COLLECT_LAST_EN
    ,
    .s_last (s_last),
    .m_err  (m_err)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check1(input string name, input logic [PKT_W-1:0] act,
                        input logic [PKT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: beats accumulate in a queue; a full (or s_last-closed) queue
  // becomes the held packet until the consumer takes it.
  bit               exp_ready  = 1'b0;
  bit               exp_mvalid = 1'b0;
  bit               exp_err    = 1'b0;
  logic [PKT_W-1:0] exp_mdata  = '0;
  logic [BUS_W-1:0] got[$];
  bit               check_en = 1'b0;
  bit               closed;

  always @(negedge clk) begin
    if (check_en) begin
      check1("s_ready", PKT_W'(s_ready), PKT_W'(exp_ready));
      check1("m_valid", PKT_W'(m_valid), PKT_W'(exp_mvalid));
      if (exp_mvalid) begin
        check1("m_data", m_data, exp_mdata);
`ifdef AXIS_COLLECT_LAST_EN
        check1("m_err", PKT_W'(m_err), PKT_W'(exp_err));
`endif
      end
    end
    if (rst) begin
      exp_ready  = 1'b0;
      exp_mvalid = 1'b0;
      exp_err    = 1'b0;
      exp_mdata  = '0;
      got.delete();
      check_en   = 1'b1;
    end else if (exp_mvalid) begin
      if (m_ready) begin
        exp_mvalid = 1'b0;
        exp_ready  = 1'b1;
        exp_err    = 1'b0;
      end
    end else begin
      closed = 1'b0;
      if (exp_ready && s_valid) begin
        got.push_back(s_data);
        closed = (got.size() == N_BEATS);
`ifdef AXIS_COLLECT_LAST_EN
        exp_err   = !(closed && s_last);
        closed    = closed || s_last;
        if (closed) exp_mdata = '0;
`endif
        if (closed) begin
          for (int i = 0; i < got.size(); i++) exp_mdata[i*BUS_W +: BUS_W] = got[i];
          got.delete();
          exp_mvalid = 1'b1;
        end
      end
      exp_ready = !closed;
    end
  end

  // Packets actually handed over on the DUT pins.
  int dut_pkts = 0;
  always @(posedge clk) if (!rst && m_valid && m_ready) dut_pkts <= dut_pkts + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic [BUS_W-1:0] data, input bit last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = data;
`ifdef AXIS_COLLECT_LAST_EN
    s_last  = last;
`else
    if (last) n = 0;
`endif
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      miscompares++;
      vectors++;
      $display("FAIL beat_timeout: s_ready stayed %0b, required 1", s_ready);
    end
    step();
    s_valid = 1'b0;
    s_data  = BUS_W'($urandom);
`ifdef AXIS_COLLECT_LAST_EN
    s_last  = 1'b0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int p0;
    bit bad;

    // Reset held five cycles, ready on the first cycle after release.
    rst = 1'b1;
    repeat (5) step();
    check1("reset_s_ready", PKT_W'(s_ready), '0);
    check1("reset_m_valid", PKT_W'(m_valid), '0);
    rst = 1'b0;
    step();
    check1("ready_after_reset", PKT_W'(s_ready), PKT_W'(1));

    // Single back-to-back packet.
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) put_beat(BUS_W'(i), i == 9);
    check1("pkt0_m_valid", PKT_W'(m_valid), PKT_W'(1));
    check1("pkt0_m_data", m_data, 80'h09080706050403020100);
    check1("pkt0_bubble", PKT_W'(s_ready), '0);
    step();
    check1("pkt0_consumed", PKT_W'(m_valid), '0);
    check1("pkt0_ready_back", PKT_W'(s_ready), PKT_W'(1));

    // Randomized traffic: 100 packets, model compares every cycle.
    p0  = dut_pkts;
    cyc = 0;
    while (dut_pkts - p0 < 100 && cyc < 30000) begin
      s_valid = ($urandom_range(0, 99) < 25);
      s_data  = BUS_W'($urandom);
      m_ready = ($urandom_range(0, 99) < 20);
`ifdef AXIS_COLLECT_LAST_EN
      s_last  = ($urandom_range(0, 19) == 0);
`endif
      step();
      cyc++;
    end
    check1("random_pkt_count", PKT_W'(dut_pkts - p0 >= 100), PKT_W'(1));
    s_valid = 1'b0;
    m_ready = 1'b0;
`ifdef AXIS_COLLECT_LAST_EN
    s_last  = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Backpressure: packet held for 50 cycles with a beat waiting.
    for (int i = 0; i < 10; i++) put_beat(BUS_W'(8'h30 + i), i == 9);
    check1("bp_m_data", m_data, 80'h39383736353433323130);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    bad     = 1'b0;
    repeat (50) begin
      if (s_ready || !m_valid || m_data !== 80'h39383736353433323130) bad = 1'b1;
      step();
    end
    check1("bp_hold_50", PKT_W'(bad), '0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    for (int i = 0; i < 10; i++) put_beat(BUS_W'(8'h40 + i), i == 9);
    check1("bp_next_pkt", m_data, 80'h49484746454443424140);
    step();

    // Reset mid-packet discards partial beats.
    for (int i = 0; i < 4; i++) put_beat(BUS_W'(8'h55 + i), 1'b0);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    p0 = dut_pkts;
    for (int i = 0; i < 10; i++) put_beat(BUS_W'(8'hA0 + i), i == 9);
    check1("rst_mid_m_data", m_data, 80'hA9A8A7A6A5A4A3A2A1A0);
    step();
    check1("rst_mid_pkt_count", PKT_W'(dut_pkts - p0), PKT_W'(1));

`ifdef AXIS_COLLECT_LAST_EN
    // Early s_last closes a short packet with an error flag.
    put_beat(8'h11, 1'b0);
    put_beat(8'h22, 1'b0);
    put_beat(8'h33, 1'b1);
    check1("last_short_m_data", m_data, 80'h332211);
    check1("last_short_m_err", PKT_W'(m_err), PKT_W'(1));
    step();
    for (int i = 0; i < 10; i++) put_beat(BUS_W'(8'h60 + i), i == 9);
    check1("last_full_m_err", PKT_W'(m_err), '0);
    check1("last_full_m_data", m_data, 80'h69686766656463626160);
    step();
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
